// File: rtl/clk_div_if.sv
// Control/status bundle for clk_div_prog: run enable, divisor load handshake
// and the divided-clock outputs.
interface clk_div_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic [WIDTH-1:0] div_cur;
    logic             clkout;
    logic             rise_tick;
    logic             fall_tick;

    modport master (
        output en, div_in, div_load,
        input  div_busy, div_cur, clkout, rise_tick, fall_tick
    );

    modport slave (
        input  en, div_in, div_load,
        output div_busy, div_cur, clkout, rise_tick, fall_tick
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor changes at period wraps.
// Define CLK_DIV_ODD50_EN to add a falling-edge stage giving 50 % duty for odd divisors.
module clk_div_prog #(
    parameter int WIDTH    = 16,
    parameter int DIV_INIT = 120
) (
    input logic      clk,
    input logic      rst,
    clk_div_if.slave bus
);
    typedef logic [WIDTH-1:0] div_t;

    localparam div_t DIV_RST = div_t'(DIV_INIT);
    localparam div_t ONE     = div_t'(1);
    localparam div_t TWO     = div_t'(2);

    logic [1:0] sync_q, sync_d;
    div_t       cnt_q, cnt_d;
    div_t       cur_q, cur_d;
    div_t       pend_q, pend_d;
    div_t       half_d;
    logic       busy_q, busy_d;
    logic       clk_p_q, clk_p_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       ready;
    logic       wrap;

    // Logic runs only once the released reset has crossed both sync stages.
    assign ready = sync_q[1];
    assign wrap  = ready && (cnt_q == cur_q - ONE);

    // NOTE: every target gets a default before any branch, so no latch can be inferred.
    always_comb begin
        sync_d  = {sync_q[0], 1'b1};
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        clk_p_d = clk_p_q;
        half_d  = cur_q >> 1;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (ready) begin
            if (wrap) begin
                cnt_d  = '0;
                fall_d = 1'b1;
                if (busy_q) begin
                    cur_d  = pend_q;
                    busy_d = 1'b0;
                end
            end else if (cnt_q != '0 || bus.en) begin
                cnt_d = cnt_q + ONE;
            end

            // A load coinciding with an apply sees busy_q high and is dropped.
            if (bus.div_load && !busy_q) begin
                pend_d = (bus.div_in < TWO) ? TWO : bus.div_in;
                busy_d = 1'b1;
            end

            half_d  = cur_d >> 1;
            clk_p_d = (cnt_d >= half_d);
            rise_d  = (cnt_d == half_d);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            cur_q   <= DIV_RST;
            pend_q  <= DIV_RST;
            busy_q  <= 1'b0;
            clk_p_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            clk_p_q <= clk_p_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef CLK_DIV_ODD50_EN
    logic clk_n_q, clk_n_d;

    assign clk_n_d = clk_p_q;

    // Half-cycle delayed copy trims the high phase of odd divisors by half a clk.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_n_d;
        end
    end

    assign bus.clkout = cur_q[0] ? (clk_p_q & clk_n_q) : clk_p_q;
`else
    assign bus.clkout = clk_p_q;
`endif

    assign bus.div_busy  = busy_q;
    assign bus.div_cur   = cur_q;
    assign bus.rise_tick = rise_q;
    assign bus.fall_tick = fall_q;
endmodule
